cook_timer: RTL
===============

# cook_timer

Countdown timer for the microwave controller: holds the cook time as four BCD digits (MM:SS) entered from the keypad and decrements it once per second while the magnetron is on. It sits directly upstream of the magnetron control stage: it consumes that stage's `mag_on` and produces the `time_over` flag that stage uses to stop the magnetron. Its digit outputs also drive the display stage.

## Interface
Parameters:
- `TICK_DIV`, default 100: clock cycles per counted second. Must be ≥ 2.
- `BEEP_CYCLES`, default 50: length of the done pulse; used only when the beep feature is compiled in.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mag_on`  in  1: countdown enable, driven by magnetron control.
- `Nclear`  in  1: active-low clear, from the same debounced button that feeds magnetron control.
- `key_valid`  in  1: one-cycle strobe marking a keypad digit.
- `key_digit`  in  4: keypad value; 0–9 valid.
- `bcd_time`  out  16: {M1, M0, S1, S0} as BCD, M1 in [15:12].
- `time_over`  out  1: high while `bcd_time` == 0.
- `beep`  out  1: done pulse. Tied to 0 unless `COOK_TIMER_BEEP_EN` is defined.

## Operation
- **Reset values:** `bcd_time` = 16'h0000, prescaler = 0, `time_over` = 1, `beep` = 0. A reset applied mid-countdown aborts the countdown and restores these values on the next edge.
- **Per-edge priority:** `rst` > `Nclear` low > key entry > countdown.
- **Clear:** `Nclear` = 0 sets `bcd_time` to 0 and the prescaler to 0 on the next edge, whether or not `mag_on` is high.
- **Key entry:** requires `key_valid` = 1, `mag_on` = 0 and `key_digit` ≤ 9. The digits shift left: `bcd_time` ← {M0, S1, S0, key_digit}, and M1 is dropped.
  - `key_digit` > 9 is ignored.
  - Any key while `mag_on` = 1 is ignored.
  - A key entry also resets the prescaler to 0.
- **Countdown:** when `mag_on` = 1 and `bcd_time` ≠ 0, the prescaler increments.
  - When the prescaler equals `TICK_DIV`-1, it wraps to 0 and `bcd_time` decrements by one second.
  - S0 borrows from S1 (S0 0→9). S1 borrows from M0 with S1 0→5. M0 borrows from M1 (M0 0→9).
  - Entered seconds above 59 (e.g. 00:90) count down directly (90, 89, …) and are not normalised.
- **Pause:** `mag_on` = 0 freezes both the prescaler and `bcd_time`. Counting resumes from the held prescaler value, so a partial second is kept.
- **At zero:** when `bcd_time` = 0, the prescaler holds at 0 and no decrement or underflow occurs.
- **Output flag:** `time_over` = (`bcd_time` == 0), decoded combinationally from the registered time.

## Timing
- Key entry and clear take effect on the edge where they are sampled; `bcd_time` is visible the following cycle.
- From a prescaler value of 0, the decrement occurs on the `TICK_DIV`-th consecutive edge with `mag_on` = 1.
- Starting from 00:01 with a fresh prescaler, `time_over` rises exactly `TICK_DIV` enabled cycles after `mag_on` rises.
- If `mag_on` falls in the same cycle the prescaler would wrap, no decrement occurs.
- Latency from `bcd_time` reaching 0 to `time_over` = 1 is zero cycles, since the flag is combinational.

## Configuration
- `COOK_TIMER_BEEP_EN` defined:
  - A down-counter loads `BEEP_CYCLES` when `bcd_time` goes from 1 to 0 by countdown.
  - `beep` = 1 while that counter is nonzero.
  - A clear or a reset aborts the beep.
  - Reaching zero by clear, or a key press during the beep, does not start a beep.
- Not defined: no beep counter is built and `beep` = 0 permanently.

## Structure
- Shared package holds:
  - `BCD_MAX` = 4'd9.
  - `SEC_TENS_WRAP` = 4'd5.
  - The `bcd_time_t` 16-bit digit typedef.
  - These are shared with the display stage.
- One sub-module, `bcd_digit_down`:
  - Inputs: digit, decrement enable, wrap value.
  - Outputs: next digit, borrow-out.
  - Instantiated four times in a borrow chain.
- The prescaler, entry shifter, clear/priority logic and beep counter live in `cook_timer`.

## Test plan
All scenarios use `TICK_DIV` = 4 and `BEEP_CYCLES` = 3.

1. **Reset:** assert `rst` for 2 cycles → `bcd_time` = 0000, `time_over` = 1, `beep` = 0.
2. **Entry and rejects:** keys 1, 3, 0 with `mag_on` = 0 → `bcd_time` = 0130, `time_over` = 0. Then key 12 → unchanged. Then key 5 with `mag_on` = 1 → unchanged.
3. **Borrow chain:** load 0100, hold `mag_on` = 1 for 8 cycles → 0059 after cycle 4, 0058 after cycle 8.
4. **Reach zero:** load 0002, `mag_on` = 1 continuous → `time_over` = 1 after exactly 8 cycles, then `bcd_time` stays 0000. With the macro defined, `beep` is high for 3 cycles.
5. **Pause and resume:** load 0005, run 2 cycles, drop `mag_on` for 5 cycles, restore → decrement to 0004 occurs after 2 more enabled cycles.
6. **Clear races:** `Nclear` = 0 with `key_valid` = 1 in the same cycle mid-countdown → `bcd_time` = 0000, `time_over` = 1, no beep.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook timer and the display stage: BCD limits and the MM:SS digit type.
package cook_timer_pkg;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

    // {M1, M0, S1, S0}, M1 in [15:12]
    typedef logic [15:0] bcd_time_t;

endpackage

// File: rtl/cook_timer_if.sv
// Control and status bundle between the cook timer, magnetron control, keypad and display.
interface cook_timer_if;
    import cook_timer_pkg::*;

    logic       mag_on;
    logic       Nclear;
    logic       key_valid;
    logic [3:0] key_digit;
    bcd_time_t  bcd_time;
    logic       time_over;
    logic       beep;

    modport master (
        output mag_on, Nclear, key_valid, key_digit,
        input  bcd_time, time_over, beep
    );

    modport slave (
        input  mag_on, Nclear, key_valid, key_digit,
        output bcd_time, time_over, beep
    );

endinterface

// File: rtl/cook_timer_bcd_digit_down.sv
// One BCD digit of the countdown borrow chain: decrements, or wraps to 'wrap' and borrows at 0.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic       dec_en,
    input  logic [3:0] wrap,
    output logic [3:0] next_digit,
    output logic       borrow
);

    always_comb begin
        next_digit = digit;
        borrow     = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                next_digit = wrap;
                borrow     = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cook_timer.sv
// MM:SS BCD countdown timer with keypad entry, clear and one-second prescaler.
// Optional done pulse on 'beep' when COOK_TIMER_BEEP_EN is defined.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned BEEP_CYCLES = 50
) (
    input  logic         clk,
    input  logic         rst,
    cook_timer_if.slave  bus
);

    localparam int unsigned     PrescW   = $clog2(TICK_DIV);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("cook_timer: TICK_DIV must be at least 2");
    end
    if (BEEP_CYCLES < 1) begin : g_bad_beep_cycles
        $error("cook_timer: BEEP_CYCLES must be at least 1");
    end

    bcd_time_t         time_q, time_d, dec_time;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [4:0]        borrow;
    logic              running, wrap_now, key_ok;

    assign running  = bus.mag_on && (time_q != '0);
    assign wrap_now = running && (presc_q == PrescMax);
    assign key_ok   = bus.key_valid && !bus.mag_on && (bus.key_digit <= BCD_MAX);

    assign borrow[0] = wrap_now;

    bcd_digit_down u_s0 (
        .digit      (time_q[3:0]),
        .dec_en     (borrow[0]),
        .wrap       (BCD_MAX),
        .next_digit (dec_time[3:0]),
        .borrow     (borrow[1])
    );

    bcd_digit_down u_s1 (
        .digit      (time_q[7:4]),
        .dec_en     (borrow[1]),
        .wrap       (SEC_TENS_WRAP),
        .next_digit (dec_time[7:4]),
        .borrow     (borrow[2])
    );

    bcd_digit_down u_m0 (
        .digit      (time_q[11:8]),
        .dec_en     (borrow[2]),
        .wrap       (BCD_MAX),
        .next_digit (dec_time[11:8]),
        .borrow     (borrow[3])
    );

    bcd_digit_down u_m1 (
        .digit      (time_q[15:12]),
        .dec_en     (borrow[3]),
        .wrap       (BCD_MAX),
        .next_digit (dec_time[15:12]),
        .borrow     (borrow[4])
    );

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        if (!bus.Nclear) begin
            time_d  = '0;
            presc_d = '0;
        end else if (key_ok) begin
            time_d  = {time_q[11:0], bus.key_digit};
            presc_d = '0;
        end else if (running) begin
            if (wrap_now) begin
                presc_d = '0;
                // Running implies a nonzero time, so the top digit never borrows; guard anyway.
                time_d  = borrow[4] ? time_q : dec_time;
            end else begin
                presc_d = presc_q + PrescW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q  <= '0;
            presc_q <= '0;
        end else begin
            time_q  <= time_d;
            presc_q <= presc_d;
        end
    end

    assign bus.bcd_time  = time_q;
    assign bus.time_over = (time_q == '0);

`ifdef COOK_TIMER_BEEP_EN
    localparam int unsigned BeepW = $clog2(BEEP_CYCLES + 1);

    logic [BeepW-1:0] beep_q, beep_d;

    // Only a countdown step from 00:01 starts the pulse; clear aborts it.
    always_comb begin
        beep_d = beep_q;
        if (!bus.Nclear) begin
            beep_d = '0;
        end else if (wrap_now && (time_q == 16'h0001)) begin
            beep_d = BeepW'(BEEP_CYCLES);
        end else if (beep_q != '0) begin
            beep_d = beep_q - BeepW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q <= '0;
        end else begin
            beep_q <= beep_d;
        end
    end

    assign bus.beep = (beep_q != '0);
`else
    assign bus.beep = 1'b0;
`endif

endmodule
